input_port_vc_buffer: RTL
=========================

Name: input_port_vc_buffer

Overview:
- Per-input-port block sitting directly upstream of switch_allocator: buffers incoming flits in VC_NUM per-VC circular FIFOs.
- Runs a per-VC packet state machine (IDLE/VA/ACTIVE).
- Presents out_port, downstream_vc and switch_request to the switch allocator.
- Pops the granted VC's head flit toward the crossbar and generates on/off flow control back to the upstream router.

Parameters:
- VC_NUM, 2, number of virtual channels; VC_SIZE = $clog2(VC_NUM) (package constant).
- BUFFER_SIZE, 8, flits per VC FIFO; power of two.
- OFF_THRESHOLD, 2, free slots at or below which on_off_o[v] is deasserted.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flit_valid_i  in  1  incoming flit valid
- flit_i  in  flit_t  incoming flit (type, vc_id, out_port for head, payload)
- on_off_o  out  VC_NUM  per-VC "may send" to upstream router
- va_request_o  out  VC_NUM  per-VC request to VC allocator
- va_out_port_o  out  port_t[VC_NUM]  requested output port
- va_grant_i  in  VC_NUM  VC allocator grant
- va_downstream_vc_i  in  VC_SIZE[VC_NUM]  allocated downstream VC
- out_port_o  out  port_t[VC_NUM]  to switch allocator
- downstream_vc_o  out  VC_SIZE[VC_NUM]  to switch allocator
- switch_request_o  out  VC_NUM  to switch allocator
- valid_sel_i  in  1  switch allocator granted this port
- vc_sel_i  in  VC_SIZE  granted VC
- flit_o  out  flit_t  flit to crossbar, vc_id rewritten to downstream VC
- overflow_o  out  1  sticky error: write to full VC

Behaviour:
- Reset (rst=1 at a clk edge), effective mid-operation:
  - all FIFOs emptied (pointers and counts 0), all FSMs IDLE, stored out_port/downstream_vc cleared to 0;
  - on_off_o all 1, all requests 0, flit_o 0, overflow_o 0.
  - In-flight packets are discarded.
- Write: flit_valid_i pushes flit_i into FIFO flit_i.vc_id at the edge.
  - Flit is visible at FIFO head the next cycle.
  - Push to a full VC is dropped: FIFO unchanged, overflow_o set until reset.
- Pointers are log2(BUFFER_SIZE) bits and wrap modulo BUFFER_SIZE; count is log2(BUFFER_SIZE)+1 bits.
- Simultaneous push and pop on the same VC: count unchanged; legal even when full (pop frees the slot in the same edge, write accepted).
- on_off_o[v] = (BUFFER_SIZE - count_next[v]) > OFF_THRESHOLD, registered, so it reflects occupancy after the current edge.
- Per-VC FSM:
  - IDLE: when FIFO non-empty and head type is HEAD or HEADTAIL, latch head out_port and go to VA. A non-head flit at the head in IDLE is popped and discarded.
  - VA: va_request_o[v]=1, va_out_port_o[v]=latched port. On va_grant_i[v], latch va_downstream_vc_i[v] and go to ACTIVE.
  - ACTIVE: switch_request_o[v] = FIFO non-empty; out_port_o/downstream_vc_o hold the latched values.
    - On valid_sel_i with vc_sel_i==v: pop the head.
    - If the popped flit is TAIL or HEADTAIL, go to IDLE the next cycle.
    - A following head already queued re-enters VA after one IDLE cycle.
- Pop output: flit_o is registered, 1-cycle latency after the grant edge, with vc_id replaced by downstream_vc.
- valid_sel_i for a VC not in ACTIVE or empty is ignored; flit_o is held.
- va_grant_i outside VA is ignored.
- Latency: a head written at edge t gives VA request at t+1; grant at edge t+1 gives switch_request at t+2.

Decomposition:
- noc_params holds flit_t, flit_type_t (HEAD/BODY/TAIL/HEADTAIL), port_t, VC_NUM, VC_SIZE, BUFFER_SIZE and a vc_state_t enum (IDLE/VA/ACTIVE).
- One sub-module, circular_buffer (per-VC FIFO: push, pop, head data, count, full/empty), instantiated VC_NUM times via generate.
- The FSM and muxing stay in the top module.

Test Plan:
- Reset: hold rst 2 cycles after random traffic -> on_off_o=2'b11, all requests 0, flit_o=0, overflow_o=0.
- Single HEADTAIL on VC1, out_port=EAST:
  - va_request_o=2'b10 next cycle with va_out_port_o[1]=EAST;
  - grant with downstream VC 0 -> switch_request_o[1]=1;
  - valid_sel_i=1, vc_sel_i=1 -> flit_o.vc_id=0 one cycle later; VC1 returns to IDLE.
- 4-flit packet HEAD/BODY/BODY/TAIL on VC0, grant every cycle -> four consecutive flit_o in order; FSM back to IDLE after TAIL; switch_request_o[0] drops when empty.
- Fill VC0 with 8 flits, no grant:
  - on_off_o[0] falls once free slots reach 2;
  - 9th push dropped and overflow_o=1;
  - simultaneous push+pop at full -> count stays 8, no overflow.
- Wrap-around: push and pop 20 flits through VC1 with varying gaps -> output order and payloads match input exactly.
- Reset asserted while VC0 is ACTIVE mid-packet -> next cycle FSM IDLE, FIFO empty, switch_request_o=0.

Source files
------------

// File: rtl/noc_params.sv
// Shared NoC types and sizing constants for the input-port VC buffer.
package noc_params;
  localparam int VC_NUM      = 2;
  localparam int VC_SIZE     = $clog2(VC_NUM);
  localparam int BUFFER_SIZE = 8;
  localparam int CNT_W       = $clog2(BUFFER_SIZE) + 1;
  localparam int DATA_W      = 16;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_type_t;

  typedef logic [2:0] port_t;
  localparam port_t LOCAL = 3'd0;
  localparam port_t NORTH = 3'd1;
  localparam port_t EAST  = 3'd2;
  localparam port_t SOUTH = 3'd3;
  localparam port_t WEST  = 3'd4;

  typedef struct packed {
    flit_type_t          flit_type;
    logic [VC_SIZE-1:0]  vc_id;
    port_t               out_port;
    logic [DATA_W-1:0]   payload;
  } flit_t;

  typedef enum logic [1:0] {IDLE, VA, ACTIVE} vc_state_t;

  function automatic logic starts_packet(input flit_type_t t);
    return (t == HEAD) || (t == HEADTAIL);
  endfunction

  function automatic logic ends_packet(input flit_type_t t);
    return (t == TAIL) || (t == HEADTAIL);
  endfunction
endpackage

// File: rtl/circular_buffer.sv
// Single-VC flit FIFO: circular storage with a combinational head view so a
// flit written at one edge is visible at the head in the following cycle.
module circular_buffer
  import noc_params::*;
#(
  parameter int DEPTH = BUFFER_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  flit_t                  data_in,
  output flit_t                  head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  flit_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A pop in the same edge frees a slot, so a push to a full FIFO still lands.
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/input_port_vc_buffer.sv
// Input port of a NoC router: per-VC flit FIFOs, per-VC packet FSM feeding the
// VC and switch allocators, registered crossbar output and on/off flow control.
module input_port_vc_buffer
  import noc_params::*;
#(
  parameter int OFF_THRESHOLD = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flit_valid_i,
  input  flit_t                             flit_i,
  output logic [VC_NUM-1:0]                 on_off_o,
  output logic [VC_NUM-1:0]                 va_request_o,
  output port_t [VC_NUM-1:0]                va_out_port_o,
  input  logic [VC_NUM-1:0]                 va_grant_i,
  input  logic [VC_NUM-1:0][VC_SIZE-1:0]    va_downstream_vc_i,
  output port_t [VC_NUM-1:0]                out_port_o,
  output logic [VC_NUM-1:0][VC_SIZE-1:0]    downstream_vc_o,
  output logic [VC_NUM-1:0]                 switch_request_o,
  input  logic                              valid_sel_i,
  input  logic [VC_SIZE-1:0]                vc_sel_i,
  output flit_t                             flit_o,
  output logic                              overflow_o
);
  vc_state_t          state_reg     [VC_NUM];
  vc_state_t          state_next    [VC_NUM];
  port_t              out_port_reg  [VC_NUM];
  logic [VC_SIZE-1:0] dvc_reg       [VC_NUM];
  flit_t              head          [VC_NUM];
  logic [CNT_W-1:0]   count         [VC_NUM];
  logic [CNT_W-1:0]   cnt_next      [VC_NUM];
  logic [VC_NUM-1:0]  push;
  logic [VC_NUM-1:0]  push_ok;
  logic [VC_NUM-1:0]  pop;
  logic [VC_NUM-1:0]  sel_pop;
  logic [VC_NUM-1:0]  drop;
  logic [VC_NUM-1:0]  full;
  logic [VC_NUM-1:0]  empty;
  logic [VC_NUM-1:0]  head_start;
  logic [VC_NUM-1:0]  head_end;

  for (genvar gi = 0; gi < VC_NUM; gi++) begin : g_vc
    assign push[gi] = flit_valid_i && (flit_i.vc_id == VC_SIZE'(gi));

    circular_buffer #(.DEPTH(BUFFER_SIZE)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .push    (push[gi]),
      .pop     (pop[gi]),
      .data_in (flit_i),
      .head    (head[gi]),
      .count   (count[gi]),
      .full    (full[gi]),
      .empty   (empty[gi])
    );

    assign head_start[gi] = starts_packet(head[gi].flit_type);
    assign head_end[gi]   = ends_packet(head[gi].flit_type);
    assign sel_pop[gi]    = valid_sel_i && (vc_sel_i == VC_SIZE'(gi)) &&
                            (state_reg[gi] == ACTIVE) && !empty[gi];
    // Orphan body/tail flits reaching the head outside a packet are discarded.
    assign pop[gi]        = sel_pop[gi] ||
                            ((state_reg[gi] == IDLE) && !empty[gi] && !head_start[gi]);
    assign push_ok[gi]    = push[gi] && (!full[gi] || pop[gi]);
    assign drop[gi]       = push[gi] && !push_ok[gi];
    assign cnt_next[gi]   = count[gi] + CNT_W'(push_ok[gi]) - CNT_W'(pop[gi]);

    assign va_request_o[gi]     = (state_reg[gi] == VA);
    assign va_out_port_o[gi]    = out_port_reg[gi];
    assign out_port_o[gi]       = out_port_reg[gi];
    assign downstream_vc_o[gi]  = dvc_reg[gi];
    assign switch_request_o[gi] = (state_reg[gi] == ACTIVE) && !empty[gi];
  end

  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      state_next[v] = state_reg[v];
      unique case (state_reg[v])
        IDLE:    if (!empty[v] && head_start[v]) state_next[v] = VA;
        VA:      if (va_grant_i[v]) state_next[v] = ACTIVE;
        ACTIVE:  if (sel_pop[v] && head_end[v]) state_next[v] = IDLE;
        default: state_next[v] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        state_reg[v]    <= IDLE;
        out_port_reg[v] <= '0;
        dvc_reg[v]      <= '0;
        on_off_o[v]     <= 1'b1;
      end
      flit_o     <= '0;
      overflow_o <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        state_reg[v] <= state_next[v];
        if ((state_reg[v] == IDLE) && !empty[v] && head_start[v]) begin
          out_port_reg[v] <= head[v].out_port;
        end
        if ((state_reg[v] == VA) && va_grant_i[v]) begin
          dvc_reg[v] <= va_downstream_vc_i[v];
        end
        // Registered so upstream sees the occupancy this edge leaves behind.
        on_off_o[v] <= (BUFFER_SIZE - int'(cnt_next[v])) > OFF_THRESHOLD;
      end
      if (|sel_pop) begin
        flit_o       <= head[vc_sel_i];
        flit_o.vc_id <= dvc_reg[vc_sel_i];
      end
      if (|drop) begin
        overflow_o <= 1'b1;
      end
    end
  end
endmodule
